// File: rtl/kp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : kp_pkg
// Description : Shared types, key legend map and small helper functions for
//               the hex keypad entry block.
// Revision    : 1.0 - initial release
// ============================================================================
package kp_pkg;

    // Scan FSM state encoding.
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // Key legend indexed by {row_idx, col_idx}. The identity map gives
    // code = row*4 + col; a board variant can reorder this to match the
    // printed legend without touching the scan logic.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h0, 4'h1, 4'h2, 4'h3,
        4'h4, 4'h5, 4'h6, 4'h7,
        4'h8, 4'h9, 4'hA, 4'hB,
        4'hC, 4'hD, 4'hE, 4'hF
    };

    // Index of the single set bit in a one-hot nibble.
    function automatic logic [1:0] onehot4_idx(input logic [3:0] oh);
        logic [1:0] idx;
        case (oh)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // True when exactly one bit of an active-low nibble is low.
    function automatic logic single_low4(input logic [3:0] v);
        logic res;
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

endpackage : kp_pkg
`default_nettype wire

// File: rtl/hex_keypad_entry_if.sv
`default_nettype none
// ============================================================================
// Interface   : hex_keypad_entry_if
// Description : Keypad matrix pins plus the key/accumulator output bus.
//               slave  - the keypad entry block
//               master - the board / environment side
// Ports       : row (4, active-low sense), col (4, active-low drive),
//               key_code (4), key_valid (1), value (32), acc_clr (1)
// Revision    : 1.0 - initial release
// ============================================================================
interface hex_keypad_entry_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [31:0] value;
    logic        acc_clr;

    modport slave (
        input  row,
        input  acc_clr,
        output col,
        output key_code,
        output key_valid,
        output value
    );

    modport master (
        output row,
        output acc_clr,
        input  col,
        input  key_code,
        input  key_valid,
        input  value
    );
endinterface : hex_keypad_entry_if
`default_nettype wire

// File: rtl/kp_debounce_cnt.sv
`default_nettype none
// ============================================================================
// Module      : kp_debounce_cnt
// Description : Consecutive-match counter. Counts cycles while match_i is
//               high and restarts on any miss or on clear_i. done_o is high
//               on the DEB_CYC-th consecutive matching cycle.
// Ports       : clk, clr (sync active-high reset), clear_i (restart count),
//               match_i (pattern still matches), done_o (stable long enough)
// Revision    : 1.0 - initial release
// ============================================================================
module kp_debounce_cnt #(
    parameter int DEB_CYC = 1000000,
    parameter int CW      = 21
) (
    input  wire logic clk,
    input  wire logic clr,
    input  wire logic clear_i,
    input  wire logic match_i,
    output logic      done_o
);

    logic [CW-1:0] cnt_q;

    // Combinational done: the counter holds the number of matching cycles
    // already seen, so the current matching cycle is number cnt_q+1.
    assign done_o = match_i && (cnt_q == CW'(DEB_CYC - 1));

    always_ff @(posedge clk) begin
        if (clr || clear_i || !match_i) begin
            cnt_q <= '0;
        end else if (!done_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule : kp_debounce_cnt
`default_nettype wire

// File: rtl/hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : hex_keypad_entry
// Description : 4x4 hex keypad scanner with debounce, multi-key rejection,
//               one-cycle key strobe and a 32-bit shift-entry accumulator.
// Ports       : clk  - system clock
//               clr  - synchronous active-high reset
//               kp   - hex_keypad_entry_if.slave: row/col matrix pins,
//                      key_code, key_valid, value, acc_clr
// Timing      : SCAN samples the synchronized rows on the SETTLE_CYC-th
//               cycle a column is driven (settle_q == SETTLE_CYC-1), so an
//               idle column lasts exactly SETTLE_CYC cycles. DEBOUNCE accepts
//               on its DEB_CYC-th consecutive matching cycle and key_valid is
//               registered, so it rises DEB_CYC+1 cycles after the sampling
//               cycle. HELD returns to SCAN after DEB_CYC consecutive
//               all-high cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_keypad_entry
    import kp_pkg::*;
#(
    parameter int SETTLE_CYC = 1000,
    parameter int DEB_CYC    = 1000000
) (
    input  wire logic          clk,
    input  wire logic          clr,
    hex_keypad_entry_if.slave  kp
);

    localparam int MAX_CYC = (SETTLE_CYC > DEB_CYC) ? SETTLE_CYC : DEB_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [1:0] ST_SCAN     = SCAN;
    localparam logic [1:0] ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] ST_HELD     = HELD;

    // Row synchronizer (rows are asynchronous to clk).
    logic [3:0]    sync1_q;
    logic [3:0]    rs_q;

    logic [1:0]    state_q,     state_d;
    logic [1:0]    cidx_q,      cidx_d;
    logic [CW-1:0] settle_q,    settle_d;
    logic [3:0]    pat_q,       pat_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [31:0]   value_q,     value_d;

    logic          deb_clear;
    logic          deb_match;
    logic          deb_done;

    kp_debounce_cnt #(
        .DEB_CYC (DEB_CYC),
        .CW      (CW)
    ) u_deb (
        .clk     (clk),
        .clr     (clr),
        .clear_i (deb_clear),
        .match_i (deb_match),
        .done_o  (deb_done)
    );

    always_comb begin
        state_d     = state_q;
        cidx_d      = cidx_q;
        settle_d    = settle_q;
        pat_d       = pat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        deb_clear   = 1'b0;
        deb_match   = 1'b0;

        case (state_q)
            ST_SCAN: begin
                // Keep the stable counter idle so it starts from zero on entry
                // to DEBOUNCE or HELD.
                deb_clear = 1'b1;
                if (settle_q < CW'(SETTLE_CYC - 1)) begin
                    settle_d = settle_q + CW'(1);
                end else begin
                    settle_d = '0;
                    if (rs_q == 4'hF) begin
                        cidx_d = cidx_q + 2'd1;
                    end else if (single_low4(rs_q)) begin
                        pat_d   = rs_q;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        // Several rows low on one column: ghost/multi-key,
                        // wait for a clean release without emitting a key.
                        state_d = ST_HELD;
                    end
                end
            end

            ST_DEBOUNCE: begin
                deb_match = (rs_q == pat_q);
                if (!deb_match) begin
                    // settle_q is already zero, so the same column re-settles.
                    state_d = ST_SCAN;
                end else if (deb_done) begin
                    key_code_d  = KEYMAP[{onehot4_idx(~pat_q), cidx_q}];
                    key_valid_d = 1'b1;
                    deb_clear   = 1'b1;
                    state_d     = ST_HELD;
                end
            end

            ST_HELD: begin
                deb_match = (rs_q == 4'hF);
                if (deb_done) begin
                    cidx_d    = cidx_q + 2'd1;
                    deb_clear = 1'b1;
                    state_d   = ST_SCAN;
                end
            end

            default: begin
                state_d  = ST_SCAN;
                settle_d = '0;
            end
        endcase

        // Clear beats a simultaneous key shift.
        if (kp.acc_clr) begin
            value_d = '0;
        end else if (key_valid_q) begin
            value_d = {value_q[27:0], key_code_q};
        end else begin
            value_d = value_q;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q     <= 4'hF;
            rs_q        <= 4'hF;
            state_q     <= ST_SCAN;
            cidx_q      <= 2'd0;
            settle_q    <= '0;
            pat_q       <= 4'hF;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            value_q     <= 32'h0;
        end else begin
            sync1_q     <= kp.row;
            rs_q        <= sync1_q;
            state_q     <= state_d;
            cidx_q      <= cidx_d;
            settle_q    <= settle_d;
            pat_q       <= pat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
        end
    end

    assign kp.col       = ~(4'b0001 << cidx_q);
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.value     = value_q;

endmodule : hex_keypad_entry
`default_nettype wire

// File: tb/tb_hex_keypad_entry.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_keypad_entry
// Description : Directed self-checking bench for hex_keypad_entry with
//               SETTLE_CYC=4, DEB_CYC=8 and a behavioural 4x4 key matrix.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hex_keypad_entry;

    localparam int SETTLE = 4;
    localparam int DEB    = 8;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] held = 16'h0;   // bit r*4+c = key at row r, column c pressed
    logic [3:0]  row_m;

    int checks   = 0;
    int failures = 0;
    int kv_cnt   = 0;
    logic [3:0] last_code = 4'h0;

    hex_keypad_entry_if kif();

    hex_keypad_entry #(
        .SETTLE_CYC (SETTLE),
        .DEB_CYC    (DEB)
    ) dut (
        .clk (clk),
        .clr (clr),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held[r*4+c] && !kif.col[c]) row_m[r] = 1'b0;
    end
    assign kif.row = row_m;

    always @(negedge clk) begin
        if (kif.key_valid) begin
            kv_cnt    <= kv_cnt + 1;
            last_code <= kif.key_code;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_key(output bit got);
        int start;
        start = kv_cnt;
        got   = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (kv_cnt != start) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_col(input logic [3:0] c, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (kif.col == c) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        kif.acc_clr = 1'b0;
        held = 16'h0;
        tick(3);
        checks++; if (kif.col !== 4'b1110) begin failures++; $display("FAIL reset_col got=%b exp=1110", kif.col); end
        checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL reset_kv got=%b exp=0", kif.key_valid); end
        checks++; if (kif.key_code !== 4'h0) begin failures++; $display("FAIL reset_code got=%h exp=0", kif.key_code); end
        checks++; if (kif.value !== 32'h0) begin failures++; $display("FAIL reset_value got=%h exp=0", kif.value); end
        clr = 1'b0;
    endtask

    task automatic test_idle();
        logic [3:0] seq [5];
        logic [3:0] exp_seq [5];
        logic [3:0] prev;
        int n, runlen, minrun, start;
        bit first;
        exp_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        start  = kv_cnt;
        prev   = kif.col;
        seq[0] = kif.col;
        n = 1; runlen = 1; minrun = 1000; first = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (kif.col !== prev) begin
                if (!first && runlen < minrun) minrun = runlen;
                first = 1'b0;
                runlen = 1;
                if (n < 5) begin seq[n] = kif.col; n++; end
                prev = kif.col;
            end else begin
                runlen++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (k >= n || seq[k] !== exp_seq[k]) begin
                failures++; $display("FAIL idle_col_seq[%0d] got=%b exp=%b", k, seq[k], exp_seq[k]);
            end
        end
        checks++; if (minrun < SETTLE) begin failures++; $display("FAIL idle_col_period got=%0d exp>=%0d", minrun, SETTLE); end
        checks++; if (kv_cnt != start) begin failures++; $display("FAIL idle_no_key got=%0d exp=0", kv_cnt - start); end
        checks++; if (kif.value !== 32'h0) begin failures++; $display("FAIL idle_value got=%h exp=0", kif.value); end
    endtask

    task automatic test_single_press();
        int start;
        bit got;
        start = kv_cnt;
        held = 16'h1 << 6;    // row1, col2
        wait_key(got);
        checks++; if (!got) begin failures++; $display("FAIL press_timeout got=none exp=key"); end
        checks++; if (last_code !== 4'h6) begin failures++; $display("FAIL press_code got=%h exp=6", last_code); end
        tick(90);
        checks++; if (kv_cnt - start != 1) begin failures++; $display("FAIL press_count got=%0d exp=1", kv_cnt - start); end
        checks++; if (kif.value !== 32'h6) begin failures++; $display("FAIL press_value got=%h exp=6", kif.value); end
        checks++; if (kif.col !== 4'b1011) begin failures++; $display("FAIL press_col_frozen got=%b exp=1011", kif.col); end
        held = 16'h0;
        got = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (kif.col !== 4'b1011) begin got = 1'b1; break; end
        end
        checks++; if (!got || kif.col !== 4'b0111) begin failures++; $display("FAIL press_resume_col got=%b exp=0111", kif.col); end
        tick(10);
    endtask

    task automatic test_bounce();
        int start;
        bit got;
        start = kv_cnt;
        for (int i = 0; i < 10; i++) begin
            held[0] = ~held[0];
            tick(3);
        end
        checks++; if (kv_cnt != start) begin failures++; $display("FAIL bounce_no_key got=%0d exp=0", kv_cnt - start); end
        held[0] = 1'b1;
        wait_key(got);
        checks++; if (!got) begin failures++; $display("FAIL bounce_timeout got=none exp=key"); end
        checks++; if (last_code !== 4'h0) begin failures++; $display("FAIL bounce_code got=%h exp=0", last_code); end
        tick(20);
        checks++; if (kv_cnt - start != 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", kv_cnt - start); end
        held = 16'h0;
        tick(30);
    endtask

    task automatic test_sequence();
        int keys [9];
        int start;
        bit got;
        keys  = '{1, 2, 3, 10, 11, 12, 13, 14, 15};
        start = kv_cnt;
        for (int k = 0; k < 9; k++) begin
            held = 16'h1 << keys[k];
            wait_key(got);
            checks++;
            if (!got || last_code !== 4'(keys[k])) begin
                failures++; $display("FAIL seq_code[%0d] got=%h exp=%h", k, last_code, 4'(keys[k]));
            end
            tick(5);
            held = 16'h0;
            tick(30);
        end
        checks++; if (kv_cnt - start != 9) begin failures++; $display("FAIL seq_count got=%0d exp=9", kv_cnt - start); end
        checks++; if (kif.value !== 32'h23ABCDEF) begin failures++; $display("FAIL seq_value got=%h exp=23abcdef", kif.value); end
    endtask

    task automatic test_multi_key();
        int start;
        bit got;
        start = kv_cnt;
        held = (16'h1 << 1) | (16'h1 << 9);    // rows 0 and 2 on column 1
        tick(100);
        checks++; if (kv_cnt != start) begin failures++; $display("FAIL multi_no_key got=%0d exp=0", kv_cnt - start); end
        checks++; if (kif.col !== 4'b1101) begin failures++; $display("FAIL multi_col_frozen got=%b exp=1101", kif.col); end
        held = 16'h0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (kif.col !== 4'b1101) begin got = 1'b1; break; end
        end
        checks++; if (!got || kif.col !== 4'b1011) begin failures++; $display("FAIL multi_resume_col got=%b exp=1011", kif.col); end
        checks++; if (kif.value !== 32'h23ABCDEF) begin failures++; $display("FAIL multi_value got=%h exp=23abcdef", kif.value); end
        tick(10);
    endtask

    task automatic test_acc_clr_collision();
        bit got;
        held = 16'h1 << 5;    // row1, col1
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (kif.key_valid) begin got = 1'b1; break; end
        end
        kif.acc_clr = 1'b1;
        tick(1);
        kif.acc_clr = 1'b0;
        checks++; if (!got) begin failures++; $display("FAIL accclr_timeout got=none exp=key"); end
        checks++; if (kif.value !== 32'h0) begin failures++; $display("FAIL accclr_value got=%h exp=0", kif.value); end
        checks++; if (kif.key_code !== 4'h5) begin failures++; $display("FAIL accclr_code got=%h exp=5", kif.key_code); end
        held = 16'h0;
        tick(30);
        checks++; if (kif.value !== 32'h0) begin failures++; $display("FAIL accclr_value_hold got=%h exp=0", kif.value); end
    endtask

    task automatic test_clr_mid_debounce();
        int start;
        bit got;
        // Put something in the outputs so the reset is observable.
        held = 16'h1 << 7;    // row1, col3
        wait_key(got);
        tick(3);
        held = 16'h0;
        tick(30);
        checks++; if (kif.value !== 32'h7) begin failures++; $display("FAIL clrmid_pre_value got=%h exp=7", kif.value); end
        wait_col(4'b1101, got);
        held = 16'h1 << 14;   // row3, col2
        wait_col(4'b1011, got);
        checks++; if (!got) begin failures++; $display("FAIL clrmid_col_timeout got=%b exp=1011", kif.col); end
        tick(6);              // settle (4) + sample, now a few cycles into DEBOUNCE
        start = kv_cnt;
        clr = 1'b1;
        tick(1);
        checks++; if (kif.col !== 4'b1110) begin failures++; $display("FAIL clrmid_col got=%b exp=1110", kif.col); end
        checks++; if (kif.key_valid !== 1'b0) begin failures++; $display("FAIL clrmid_kv got=%b exp=0", kif.key_valid); end
        checks++; if (kif.key_code !== 4'h0) begin failures++; $display("FAIL clrmid_code got=%h exp=0", kif.key_code); end
        checks++; if (kif.value !== 32'h0) begin failures++; $display("FAIL clrmid_value got=%h exp=0", kif.value); end
        held = 16'h0;
        tick(20);
        clr = 1'b0;
        tick(40);
        checks++; if (kv_cnt != start) begin failures++; $display("FAIL clrmid_no_key got=%0d exp=0", kv_cnt - start); end
    endtask

    initial begin
        kif.acc_clr = 1'b0;
        test_reset();
        test_idle();
        test_single_press();
        test_bounce();
        test_sequence();
        test_multi_key();
        test_acc_clr_collision();
        test_clr_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hex_keypad_entry
`default_nettype wire
